// File: rtl/sync_pkg.sv
// Shared definitions for the ff_sync_filt synchronizer: parameter limits,
// filter FSM encodings and the Gray-to-binary decode used on the candidate.
package sync_pkg;

  localparam int WIDTH_MIN  = 1;
  localparam int WIDTH_MAX  = 32;
  localparam int STAGES_MIN = 2;
  localparam int STAGES_MAX = 4;
  localparam int FILTER_MIN = 0;
  localparam int FILTER_MAX = 15;
  localparam int CNT_W      = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_QUAL = 1'b1
  } filt_state_e;

  // Each binary bit is the XOR of its Gray bit and the binary bit above it.
  // Zero-extended upper bits decode to zero, so narrower buses use the same function.
  function automatic logic [WIDTH_MAX-1:0] gray2bin(input logic [WIDTH_MAX-1:0] g);
    logic [WIDTH_MAX-1:0] b;
    b[WIDTH_MAX-1] = g[WIDTH_MAX-1];
    for (int i = WIDTH_MAX - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_filter.sv
// Stability filter: q takes a new candidate only after FILTER consecutive equal samples.
// Latency FILTER edges from the candidate changing; no backpressure, samples every edge.
module sync_filter
  import sync_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int FILTER = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_cand,
  output logic [WIDTH-1:0] o_q,
  output logic             o_changed,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);

  filt_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_hold;
  logic [WIDTH-1:0] r_q;
  logic             r_changed;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  logic             w_eq_hold;
  logic             w_eq_q;
  logic             w_commit;
  logic [WIDTH-1:0] w_q_next;

  assign w_eq_hold = (i_cand == r_hold);
  assign w_eq_q    = (i_cand == r_q);
  assign w_commit  = (r_state == ST_QUAL) && w_eq_hold && (r_cnt == CNT_LAST);
  assign w_q_next  = w_commit ? r_hold : r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_hold    <= '0;
      r_q       <= '0;
      r_changed <= 1'b0;
      r_rise    <= '0;
      r_fall    <= '0;
    end else begin
      r_q       <= w_q_next;
      r_changed <= (w_q_next != r_q);
      r_rise    <= w_q_next & ~r_q;
      r_fall    <= ~w_q_next & r_q;
      case (r_state)
        ST_IDLE: begin
          if (!w_eq_q) begin
            r_state <= ST_QUAL;
            r_hold  <= i_cand;
            r_cnt   <= CNT_ONE;
          end
        end
        ST_QUAL: begin
          if (w_eq_hold) begin
            if (r_cnt == CNT_LAST) begin
              r_state <= ST_IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end else if (w_eq_q) begin
            // Glitch collapsed back onto the current output: abandon silently.
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end else begin
            r_hold <= i_cand;
            r_cnt  <= CNT_ONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign o_q       = r_q;
  assign o_changed = r_changed;
  assign o_rise    = r_rise;
  assign o_fall    = r_fall;

endmodule

// File: rtl/ff_sync_filt.sv
// Multi-flop bus synchronizer with optional Gray decode, stability filter and edge pulses.
// Latency STAGES+1 edges in bypass, STAGES+FILTER with filter; no backpressure.
module ff_sync_filt
  import sync_pkg::*;
#(
  parameter int WIDTH  = 4,
  parameter int STAGES = 2,
  parameter int FILTER = 0,
  parameter int GRAY   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             changed,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("ff_sync_filt: STAGES out of range");
  end
  if (FILTER < FILTER_MIN || FILTER > FILTER_MAX) begin : g_bad_filter
    $error("ff_sync_filt: FILTER out of range");
  end
  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("ff_sync_filt: WIDTH out of range");
  end

  // Pure flop chain: no logic between stages so each has a full cycle to resolve.
  (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_sync[k] <= '0;
      end
    end else begin
      r_sync[0] <= din;
      for (int k = 1; k < STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  logic [WIDTH-1:0] w_cand;

  if (GRAY != 0) begin : g_gray
    assign w_cand = WIDTH'(gray2bin(WIDTH_MAX'(r_sync[STAGES-1])));
  end else begin : g_plain
    assign w_cand = r_sync[STAGES-1];
  end

  if (FILTER >= 2) begin : g_filt
    sync_filter #(
      .WIDTH  (WIDTH),
      .FILTER (FILTER)
    ) u_filt (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_cand    (w_cand),
      .o_q       (q),
      .o_changed (changed),
      .o_rise    (rise),
      .o_fall    (fall)
    );
  end else begin : g_bypass
    logic [WIDTH-1:0] r_q;
    logic             r_changed;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_q       <= '0;
        r_changed <= 1'b0;
        r_rise    <= '0;
        r_fall    <= '0;
      end else begin
        r_q       <= w_cand;
        r_changed <= (w_cand != r_q);
        r_rise    <= w_cand & ~r_q;
        r_fall    <= ~w_cand & r_q;
      end
    end

    assign q       = r_q;
    assign changed = r_changed;
    assign rise    = r_rise;
    assign fall    = r_fall;
  end

endmodule

// File: tb/tb_ff_sync_filt.sv
`timescale 1ns/1ps
module tb_ff_sync_filt;

  localparam int NI = 5;
  localparam int WD [NI] = '{4, 4, 4, 4, 6};
  localparam int ST [NI] = '{2, 3, 2, 2, 4};
  localparam int FL [NI] = '{0, 0, 4, 0, 3};
  localparam int GR [NI] = '{0, 0, 0, 1, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] din_v [NI];

  logic [3:0] din_a, din_b, din_c, din_d;
  logic [5:0] din_e;
  logic [3:0] q_a, q_b, q_c, q_d, rise_a, rise_b, rise_c, rise_d, fall_a, fall_b, fall_c, fall_d;
  logic [5:0] q_e, rise_e, fall_e;
  logic       chg_a, chg_b, chg_c, chg_d, chg_e;

  assign din_a = din_v[0][3:0];
  assign din_b = din_v[1][3:0];
  assign din_c = din_v[2][3:0];
  assign din_d = din_v[3][3:0];
  assign din_e = din_v[4][5:0];

  ff_sync_filt #(.WIDTH(4), .STAGES(2), .FILTER(0), .GRAY(0)) u_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .q(q_a), .changed(chg_a), .rise(rise_a), .fall(fall_a));
  ff_sync_filt #(.WIDTH(4), .STAGES(3), .FILTER(0), .GRAY(0)) u_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .q(q_b), .changed(chg_b), .rise(rise_b), .fall(fall_b));
  ff_sync_filt #(.WIDTH(4), .STAGES(2), .FILTER(4), .GRAY(0)) u_c (
    .clk(clk), .rst_n(rst_n), .din(din_c), .q(q_c), .changed(chg_c), .rise(rise_c), .fall(fall_c));
  ff_sync_filt #(.WIDTH(4), .STAGES(2), .FILTER(0), .GRAY(1)) u_d (
    .clk(clk), .rst_n(rst_n), .din(din_d), .q(q_d), .changed(chg_d), .rise(rise_d), .fall(fall_d));
  ff_sync_filt #(.WIDTH(6), .STAGES(4), .FILTER(3), .GRAY(1)) u_e (
    .clk(clk), .rst_n(rst_n), .din(din_e), .q(q_e), .changed(chg_e), .rise(rise_e), .fall(fall_e));

  logic [31:0] act_q [NI];
  logic [31:0] act_r [NI];
  logic [31:0] act_f [NI];
  logic        act_c [NI];

  assign act_q[0] = {28'd0, q_a};  assign act_r[0] = {28'd0, rise_a};  assign act_f[0] = {28'd0, fall_a};
  assign act_q[1] = {28'd0, q_b};  assign act_r[1] = {28'd0, rise_b};  assign act_f[1] = {28'd0, fall_b};
  assign act_q[2] = {28'd0, q_c};  assign act_r[2] = {28'd0, rise_c};  assign act_f[2] = {28'd0, fall_c};
  assign act_q[3] = {28'd0, q_d};  assign act_r[3] = {28'd0, rise_d};  assign act_f[3] = {28'd0, fall_d};
  assign act_q[4] = {26'd0, q_e};  assign act_r[4] = {26'd0, rise_e};  assign act_f[4] = {26'd0, fall_e};
  assign act_c[0] = chg_a;
  assign act_c[1] = chg_b;
  assign act_c[2] = chg_c;
  assign act_c[3] = chg_d;
  assign act_c[4] = chg_e;

  int checks = 0;
  int errors = 0;

  // Reference model: delay line of samples, then "adopt a value once it has
  // been seen FILTER times in a row" (always, for FILTER <= 1).
  logic [31:0] m_hist [NI][4];
  logic [31:0] m_q    [NI];
  logic [31:0] m_rise [NI];
  logic [31:0] m_fall [NI];
  logic        m_chg  [NI];
  logic [31:0] m_last [NI];
  int          m_run  [NI];

  function automatic logic [31:0] gray_dec(input logic [31:0] g);
    logic [31:0] b;
    b = g;
    for (int s = 1; s < 32; s++) b = b ^ (g >> s);
    return b;
  endfunction

  task automatic model_edge();
    logic [31:0] mask, cand, qn;
    for (int i = 0; i < NI; i++) begin
      mask = (32'd1 << WD[i]) - 32'd1;
      if (!rst_n) begin
        for (int k = 0; k < 4; k++) m_hist[i][k] = '0;
        m_q[i] = '0; m_rise[i] = '0; m_fall[i] = '0; m_chg[i] = 1'b0;
        m_last[i] = '0; m_run[i] = 0;
      end else begin
        cand = m_hist[i][ST[i]-1];
        if (GR[i] != 0) cand = gray_dec(cand) & mask;
        for (int k = 3; k > 0; k--) m_hist[i][k] = m_hist[i][k-1];
        m_hist[i][0] = din_v[i] & mask;
        if (cand == m_last[i]) m_run[i] = m_run[i] + 1;
        else m_run[i] = 1;
        m_last[i] = cand;
        qn = (cand != m_q[i] && m_run[i] >= FL[i]) ? cand : m_q[i];
        m_chg[i]  = (qn != m_q[i]);
        m_rise[i] = qn & ~m_q[i] & mask;
        m_fall[i] = ~qn & m_q[i] & mask;
        m_q[i]    = qn;
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (act_q[i] !== m_q[i] || act_c[i] !== m_chg[i] || act_r[i] !== m_rise[i] || act_f[i] !== m_fall[i]) begin
        errors++;
        $display("FAIL model%0d actual q=%h chg=%b rise=%h fall=%h expected q=%h chg=%b rise=%h fall=%h at %0t",
                 i, act_q[i], act_c[i], act_r[i], act_f[i], m_q[i], m_chg[i], m_rise[i], m_fall[i], $time);
      end
    end
  endtask

  task automatic set_all(input logic [31:0] v);
    for (int i = 0; i < NI; i++) din_v[i] = v;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] din;
    logic [3:0] q;
    logic       chg;
    logic [3:0] rise;
    logic [3:0] fall;
  } vec_t;

  vec_t tbl [13];

  initial begin
    logic [3:0] gin  [4];
    logic [3:0] gexp [4];

    tbl[0]  = '{1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[1]  = '{1'b0, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[2]  = '{1'b1, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[3]  = '{1'b1, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[4]  = '{1'b1, 4'hF, 4'hF, 1'b1, 4'hF, 4'h0};
    tbl[5]  = '{1'b1, 4'hF, 4'hF, 1'b0, 4'h0, 4'h0};
    tbl[6]  = '{1'b1, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0};
    tbl[7]  = '{1'b1, 4'h0, 4'hF, 1'b0, 4'h0, 4'h0};
    tbl[8]  = '{1'b1, 4'h0, 4'h0, 1'b1, 4'h0, 4'hF};
    tbl[9]  = '{1'b1, 4'h2, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[10] = '{1'b1, 4'h2, 4'h0, 1'b0, 4'h0, 4'h0};
    tbl[11] = '{1'b1, 4'h2, 4'h2, 1'b1, 4'h2, 4'h0};
    tbl[12] = '{1'b1, 4'h2, 4'h2, 1'b0, 4'h0, 4'h0};

    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 4; k++) m_hist[i][k] = '0;
      m_q[i] = '0; m_rise[i] = '0; m_fall[i] = '0; m_chg[i] = 1'b0; m_last[i] = '0; m_run[i] = 0;
    end
    rst_n = 1'b0;
    set_all(32'hF);

    // Reset with din high, release, then bypass steps on the default instance.
    for (int k = 0; k < 13; k++) begin
      rst_n = tbl[k].rst;
      set_all({28'd0, tbl[k].din});
      step();
      check($sformatf("tbl%0d", k), {51'd0, q_a, chg_a, rise_a, fall_a},
            {51'd0, tbl[k].q, tbl[k].chg, tbl[k].rise, tbl[k].fall});
    end

    set_all(32'h0);
    repeat (8) step();

    // Three-stage bypass: new value lands on the 4th edge.
    din_v[1] = 32'h2;
    for (int k = 1; k <= 4; k++) begin
      step();
      check($sformatf("stages3_q_e%0d", k), {60'd0, q_b}, (k == 4) ? 64'h2 : 64'h0);
      check($sformatf("stages3_rise_e%0d", k), {60'd0, rise_b}, (k == 4) ? 64'h2 : 64'h0);
    end

    // Filter: clean step lands on the 6th edge.
    din_v[2] = 32'h4;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("filt_step_e%0d", k), {59'd0, q_c, chg_c}, (k == 6) ? 64'h9 : 64'h0);
    end
    din_v[2] = 32'h0;
    repeat (8) step();
    check("filt_return", {60'd0, q_c}, 64'h0);

    // Filter: 2-cycle pulse is swallowed.
    din_v[2] = 32'h4;
    repeat (2) begin
      step();
      check("filt_glitch", {50'd0, q_c, chg_c, rise_c, fall_c}, 64'h0);
    end
    din_v[2] = 32'h0;
    repeat (10) begin
      step();
      check("filt_glitch", {50'd0, q_c, chg_c, rise_c, fall_c}, 64'h0);
    end

    // Filter: short 3 then steady 5 restarts qualification; 3 never appears.
    din_v[2] = 32'h3;
    repeat (2) begin
      step();
      check("filt_restart_pre", {60'd0, q_c}, 64'h0);
    end
    din_v[2] = 32'h5;
    for (int k = 1; k <= 8; k++) begin
      step();
      check($sformatf("filt_restart_e%0d", k), {60'd0, q_c}, (k >= 6) ? 64'h5 : 64'h0);
    end
    din_v[2] = 32'h0;
    repeat (8) step();

    // Filter: reset mid-qualification discards the pending value.
    din_v[2] = 32'hA;
    repeat (3) step();
    rst_n = 1'b0;
    step();
    check("filt_rst_mid", {59'd0, q_c, chg_c}, 64'h0);
    rst_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("filt_rst_rel_e%0d", k), {59'd0, q_c, chg_c}, (k == 6) ? 64'h15 : 64'h0);
    end

    // Gray decode, bypass.
    gin  = '{4'h0, 4'h1, 4'h3, 4'h2};
    gexp = '{4'h0, 4'h1, 4'h2, 4'h3};
    for (int g = 0; g < 4; g++) begin
      din_v[3] = {28'd0, gin[g]};
      for (int k = 1; k <= 5; k++) begin
        step();
        if (g == 2 && k == 3)
          check("gray_1to2", {52'd0, q_d, rise_d, fall_d}, {52'd0, 4'h2, 4'h2, 4'h1});
      end
      check($sformatf("gray_q%0d", g), {60'd0, q_d}, {60'd0, gexp[g]});
    end

    // Random stimulus against the model; values held for random lengths.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NI; i++) begin
        if ($urandom_range(0, 3) == 0) din_v[i] = $urandom & ((32'd1 << WD[i]) - 32'd1);
      end
      rst_n = ($urandom_range(0, 149) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_sync_filt.md
FF_SYNC_FILT -- requirements
Module: ff_sync_filt

Interface
REQ-001 Parameter WIDTH, default 4, bit width of synchronized bus; legal 1..32.
REQ-002 Parameter STAGES, default 2, synchronizer flop depth; legal 2..4, other values SHALL fail elaboration.
REQ-003 Parameter FILTER, default 0, stability samples required before q updates; 0 or 1 = bypass, legal 0..15.
REQ-004 Parameter GRAY, default 0; 1 = din is Gray-coded, q is its binary decode.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 din  in  WIDTH  asynchronous input bus.
REQ-008 q  out  WIDTH  synchronized, optionally decoded and filtered value.
REQ-009 changed  out  1  one-cycle pulse in the first cycle q holds a new value.
REQ-010 rise  out  WIDTH  per-bit one-cycle pulse, q bit went 0->1.
REQ-011 fall  out  WIDTH  per-bit one-cycle pulse, q bit went 1->0.

Function
REQ-012 Chain s[0..STAGES-1]: s[0]<=din, s[k]<=s[k-1] each edge; no logic between stages.
REQ-013 Candidate cand = s[STAGES-1] when GRAY=0, gray2bin(s[STAGES-1]) when GRAY=1 (bin[MSB]=g[MSB], bin[i]=bin[i+1]^g[i]).
REQ-014 Bypass (FILTER<=1): q<=cand every edge; latency STAGES+1 edges from din sampling edge, inclusive.
REQ-015 Filter (FILTER>=2): FSM states IDLE, QUAL; 4-bit counter cnt; WIDTH-bit hold register.
REQ-016 IDLE: cand!=q -> QUAL, hold<=cand, cnt<=1; else stay.
REQ-017 QUAL, cand==hold, cnt==FILTER-1: q<=hold, -> IDLE, cnt<=0.
REQ-018 QUAL, cand==hold, cnt<FILTER-1: cnt<=cnt+1.
REQ-019 QUAL, cand!=hold, cand==q: -> IDLE, cnt<=0, q unchanged, no pulses.
REQ-020 QUAL, cand!=hold, cand!=q: hold<=cand, cnt<=1 (restart qualification).
REQ-021 Filter latency STAGES+FILTER edges for a clean step; any input pulse shorter than FILTER cycles at cand SHALL NOT reach q.
REQ-022 changed, rise, fall registered on the same edge that updates q: changed=(q_next!=q), rise=q_next&~q, fall=~q_next&q; all cleared next edge unless q updates again.
REQ-023 In bypass, back-to-back cand changes SHALL produce back-to-back pulses, one per change.

Reset
REQ-024 rst_n low at an edge: s[*]=0, q=0, hold=0, cnt=0, FSM=IDLE, changed=0, rise=0, fall=0.
REQ-025 Reset mid-qualification SHALL discard pending hold/cnt with no pulse.
REQ-026 Nonzero din after release SHALL be treated as a normal change from 0 (rise pulses asserted).

Structure
REQ-027 Package/include sync_pkg SHALL hold gray2bin function, FSM state encodings (IDLE=0, QUAL=1), STAGES/FILTER legal limits.
REQ-028 Sub-module sync_filter (FSM, cnt, hold, q) SHALL be instantiated via generate only when FILTER>=2; bypass path otherwise.
REQ-029 Chain flops SHALL carry a synchronizer attribute (ASYNC_REG) on s[0..STAGES-1].

Verification (WIDTH=4 unless noted)
REQ-030 Reset: din=4'hF, rst_n low 2 edges -> q=0, all pulses 0; release -> q=4'hF at 3rd edge after release, rise=4'hF and changed=1 for one cycle.
REQ-031 Bypass STAGES=2: din 0->4'h2 -> q=4'h2 at 3rd edge, rise=4'b0010 one cycle; STAGES=3 -> 4th edge.
REQ-032 FILTER=4: din 0->4'h4 held -> q=4'h4 at 6th edge; din 0->4'h4 for 2 cycles then 0 -> q stays 0, no pulses.
REQ-033 GRAY=1, FILTER=0: din 0,1,3,2 each held 5 cycles -> q 0,1,2,3; 1->2 transition gives rise=4'b0010, fall=4'b0001.
REQ-034 FILTER=4: din->4'hA, rst_n low for one edge at 4th edge -> q=0, no changed; after release q=4'hA at 6th edge.
REQ-035 FILTER=4: cand 4'h3 for 2 cycles then 4'h5 held -> q=4'h5 exactly 4 cycles after 4'h5 first appears at cand, 4'h3 never seen on q.
